// File: rtl/duplex_pkg.sv
// Shared definitions for the duplex channel selector.
// Holds the selector state encoding, the default fault threshold and hold
// time, and the widths of the internal counters and the mismatch counter.
package duplex_pkg;

    typedef enum logic [1:0] {
        PRI = 2'd0,
        SEC = 2'd1,
        DD  = 2'd2
    } state_t;

    localparam int DEF_THRESH = 3;
    localparam int DEF_HOLD   = 8;

    // MISM_CNT is a fixed 8-bit port, saturating at 255.
    localparam int MISM_W = 8;

    // THRESH tops out at 15 and HOLD at 255.
    localparam int BAD_W  = 4;
    localparam int HOLD_W = 8;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with a dominant synchronous clear.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, forces count to 0
//   inc   - count up by one, stopping at LIMIT
//   clr   - force count to 0 on the next edge (wins over inc)
//   count - current count
module sat_cnt #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    // Count register: clear dominates, otherwise climb until the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/duplex_sel_ctrl.sv
// Duplex channel selection controller.
// Watches two redundant channels, declares a channel faulty after THRESH
// consecutive invalid cycles and steers the external 2:1 mux select away
// from a faulty channel, rate-limited by a HOLD-cycle hold-off.
// Ports:
//   CK, R              - clock (rising edge), async active-high reset
//   A0, A1             - channel data (only compared for MISM_CNT)
//   V0, V1             - channel self-check valid flags
//   CLR                - one-cycle pulse clearing faults and counters
//   FORCE_EN, FORCE_SL - manual override of the select
//   SL                 - registered mux select (0 = A0, 1 = A1)
//   FAULT0, FAULT1     - sticky per-channel faults
//   DEAD               - both channels faulty
//   SWITCH             - one-cycle pulse after every SL change
//   MISM_CNT           - saturating count of valid-but-different samples
module duplex_sel_ctrl
    import duplex_pkg::*;
#(
    parameter int W      = 8,
    parameter int THRESH = DEF_THRESH,
    parameter int HOLD   = DEF_HOLD
) (
    input  logic              CK,
    input  logic              R,
    input  logic [W-1:0]      A0,
    input  logic [W-1:0]      A1,
    input  logic              V0,
    input  logic              V1,
    input  logic              CLR,
    input  logic              FORCE_EN,
    input  logic              FORCE_SL,
    output logic              SL,
    output logic              FAULT0,
    output logic              FAULT1,
    output logic              DEAD,
    output logic              SWITCH,
    output logic [MISM_W-1:0] MISM_CNT
);

    localparam logic [BAD_W-1:0]  THRESH_M1 = BAD_W'(THRESH - 1);
    localparam logic [HOLD_W-1:0] HOLD_V    = HOLD_W'(HOLD);
    localparam logic [MISM_W-1:0] MISM_MAX  = '1;

    logic [BAD_W-1:0]  bad0;
    logic [BAD_W-1:0]  bad1;
    logic              inc0;
    logic              inc1;
    logic              clr0;
    logic              clr1;
    logic              reach0;
    logic              reach1;
    state_t            state;
    state_t            state_next;
    logic              fsm_sel;
    logic              sl_next;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_next;

    // A valid sample restarts the run of bad cycles, as does CLR.
    assign inc0 = ~V0;
    assign inc1 = ~V1;
    assign clr0 = V0 | CLR;
    assign clr1 = V1 | CLR;

    sat_cnt #(
        .WIDTH (BAD_W),
        .LIMIT (THRESH)
    ) u_bad0 (
        .clk   (CK),
        .rst   (R),
        .inc   (inc0),
        .clr   (clr0),
        .count (bad0)
    );

    sat_cnt #(
        .WIDTH (BAD_W),
        .LIMIT (THRESH)
    ) u_bad1 (
        .clk   (CK),
        .rst   (R),
        .inc   (inc1),
        .clr   (clr1),
        .count (bad1)
    );

    // True on the edge where the counter steps onto THRESH.
    assign reach0 = inc0 && (bad0 == THRESH_M1);
    assign reach1 = inc1 && (bad1 == THRESH_M1);

    // Sticky faults; a threshold hit on the same edge as CLR still sets.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            FAULT0 <= 1'b0;
            FAULT1 <= 1'b0;
        end else begin
            FAULT0 <= reach0 | (FAULT0 & ~CLR);
            FAULT1 <= reach1 | (FAULT1 & ~CLR);
        end
    end

    // Disagreement counter, only counting when both channels claim valid.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            MISM_CNT <= '0;
        end else if (CLR) begin
            MISM_CNT <= '0;
        end else if (V0 && V1 && (A0 != A1) && (MISM_CNT != MISM_MAX)) begin
            MISM_CNT <= MISM_CNT + 1'b1;
        end
    end

    // Next state, select and hold-off.  The FSM looks at the registered
    // faults, so a switch lands one edge after the fault flag rises.  The
    // override drives SL directly but leaves the FSM running underneath;
    // without it, SL follows the FSM only once the hold-off has run out.
    always_comb begin
        state_next = state;
        case (state)
            PRI: begin
                if (FAULT0 && FAULT1) begin
                    state_next = DD;
                end else if (FAULT0 && (hold == '0)) begin
                    state_next = SEC;
                end
            end
            SEC: begin
                if (FAULT0 && FAULT1) begin
                    state_next = DD;
                end else if (FAULT1 && (hold == '0)) begin
                    state_next = PRI;
                end
            end
            DD: begin
                if (CLR) begin
                    state_next = PRI;
                end
            end
            default: state_next = PRI;
        endcase

        // DD keeps whatever select was last in force.
        fsm_sel = SL;
        if (state_next == PRI) begin
            fsm_sel = 1'b0;
        end else if (state_next == SEC) begin
            fsm_sel = 1'b1;
        end

        if (FORCE_EN) begin
            sl_next = FORCE_SL;
        end else if (hold == '0) begin
            sl_next = fsm_sel;
        end else begin
            sl_next = SL;
        end

        if (sl_next != SL) begin
            hold_next = HOLD_V;
        end else if (hold != '0) begin
            hold_next = hold - 1'b1;
        end else begin
            hold_next = hold;
        end
    end

    // Selector registers; SWITCH and DEAD are registered so every output
    // comes straight from a flop.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            state  <= PRI;
            SL     <= 1'b0;
            hold   <= '0;
            SWITCH <= 1'b0;
            DEAD   <= 1'b0;
        end else begin
            state  <= state_next;
            SL     <= sl_next;
            hold   <= hold_next;
            SWITCH <= (sl_next != SL);
            DEAD   <= (state_next == DD);
        end
    end

endmodule

// File: tb/tb_duplex_sel_ctrl.sv
// Self-checking bench for duplex_sel_ctrl (W=8, THRESH=3, HOLD=8).
// Expected output vectors are queued as each step is driven and popped
// when the DUT output is sampled one time unit after the clock edge.
module tb_duplex_sel_ctrl;

    logic       CK = 1'b0;
    logic       R  = 1'b0;
    logic [7:0] A0 = 8'h00;
    logic [7:0] A1 = 8'h00;
    logic       V0 = 1'b1;
    logic       V1 = 1'b1;
    logic       CLR = 1'b0;
    logic       FORCE_EN = 1'b0;
    logic       FORCE_SL = 1'b0;
    logic       SL;
    logic       FAULT0;
    logic       FAULT1;
    logic       DEAD;
    logic       SWITCH;
    logic [7:0] MISM_CNT;

    typedef struct {
        string       tag;
        logic [12:0] vec;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    duplex_sel_ctrl #(
        .W      (8),
        .THRESH (3),
        .HOLD   (8)
    ) dut (
        .CK       (CK),
        .R        (R),
        .A0       (A0),
        .A1       (A1),
        .V0       (V0),
        .V1       (V1),
        .CLR      (CLR),
        .FORCE_EN (FORCE_EN),
        .FORCE_SL (FORCE_SL),
        .SL       (SL),
        .FAULT0   (FAULT0),
        .FAULT1   (FAULT1),
        .DEAD     (DEAD),
        .SWITCH   (SWITCH),
        .MISM_CNT (MISM_CNT)
    );

    // 10-unit clock period.
    always #5 CK = ~CK;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic v0, input logic v1,
                                 input logic [7:0] a0, input logic [7:0] a1,
                                 input logic clr, input logic fen,
                                 input logic fsl);
        V0       = v0;
        V1       = v1;
        A0       = a0;
        A1       = a1;
        CLR      = clr;
        FORCE_EN = fen;
        FORCE_SL = fsl;
    endtask

    task automatic expectOut(input string tag, input logic sl, input logic f0,
                             input logic f1, input logic dead, input logic sw,
                             input logic [7:0] mism);
        exp_t e;
        e.tag = tag;
        e.vec = {sl, f0, f1, dead, sw, mism};
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [12:0] obs;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: observed no entry, required one");
            return;
        end
        e   = sb.pop_front();
        obs = {SL, FAULT0, FAULT1, DEAD, SWITCH, MISM_CNT};
        assert (obs === e.vec) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed sl/f0/f1/dead/sw/mism=%b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                   e.tag, obs[12], obs[11], obs[10], obs[9], obs[8], obs[7:0],
                   e.vec[12], e.vec[11], e.vec[10], e.vec[9], e.vec[8], e.vec[7:0]);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // Queue expectation, advance one edge, compare.
    task automatic cyc(input string tag, input logic sl, input logic f0,
                       input logic f1, input logic dead, input logic sw,
                       input logic [7:0] mism);
        expectOut(tag, sl, f0, f1, dead, sw, mism);
        step();
        checkOutput();
    endtask

    // Short reset pulse placed between clock edges.
    task automatic doReset();
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        R = 1'b1;
        #1;
        R = 1'b0;
    endtask

    initial begin
        logic [5:0] glitch;
        glitch = 6'b100100;

        // Reset state, asserted asynchronously before any clock edge.
        #1 R = 1'b1;
        expectOut("reset_async", 0, 0, 0, 0, 0, 8'd0);
        #1 checkOutput();
        cyc("reset_held", 0, 0, 0, 0, 0, 8'd0);
        R = 1'b0;

        // Failover: channel 0 invalid for three edges.
        applyStimulus(0, 1, 8'h00, 8'h00, 0, 0, 0);
        cyc("fo_bad1", 0, 0, 0, 0, 0, 8'd0);
        cyc("fo_bad2", 0, 0, 0, 0, 0, 8'd0);
        cyc("fo_fault0", 0, 1, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        cyc("fo_switch", 1, 1, 0, 0, 1, 8'd0);
        // Channel 1 now fails too while the hold-off is running.
        applyStimulus(1, 0, 8'h00, 8'h00, 0, 0, 0);
        cyc("dd_bad1", 1, 1, 0, 0, 0, 8'd0);
        cyc("dd_bad2", 1, 1, 0, 0, 0, 8'd0);
        cyc("dd_fault1", 1, 1, 1, 0, 0, 8'd0);
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        cyc("dd_dead", 1, 1, 1, 1, 0, 8'd0);
        cyc("dd_stay", 1, 1, 1, 1, 0, 8'd0);

        // Asynchronous reset in the middle of DD.
        #2 R = 1'b1;
        expectOut("dd_async_reset", 0, 0, 0, 0, 0, 8'd0);
        #1 checkOutput();
        R = 1'b0;
        cyc("post_reset_idle", 0, 0, 0, 0, 0, 8'd0);

        // CLR on the threshold edge: fault must still set.
        applyStimulus(0, 1, 8'h00, 8'h00, 0, 0, 0);
        cyc("race_bad1", 0, 0, 0, 0, 0, 8'd0);
        cyc("race_bad2", 0, 0, 0, 0, 0, 8'd0);
        applyStimulus(0, 1, 8'h00, 8'h00, 1, 0, 0);
        cyc("race_fault_wins", 0, 1, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        cyc("race_switch", 1, 1, 0, 0, 1, 8'd0);
        // CLR while in SEC clears the fault but leaves SL alone.
        applyStimulus(1, 1, 8'h00, 8'h00, 1, 0, 0);
        cyc("clr_in_sec", 1, 0, 0, 0, 0, 8'd0);
        // Channel 1 fails during hold-off: switch back waits for expiry.
        applyStimulus(1, 0, 8'h00, 8'h00, 0, 0, 0);
        cyc("hold_bad1", 1, 0, 0, 0, 0, 8'd0);
        cyc("hold_bad2", 1, 0, 0, 0, 0, 8'd0);
        cyc("hold_fault1", 1, 0, 1, 0, 0, 8'd0);
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc("hold_blocked", 1, 0, 1, 0, 0, 8'd0);
        end
        cyc("hold_expired_switch", 0, 0, 1, 0, 1, 8'd0);
        cyc("hold_back_in_pri", 0, 0, 1, 0, 0, 8'd0);

        // Glitch rejection: 0,0,1,0,0,1 on V0 never reaches three in a row.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(glitch[i], 1, 8'h00, 8'h00, 0, 0, 0);
            cyc("glitch", 0, 0, 0, 0, 0, 8'd0);
        end

        // Simultaneous first faults go straight to DD without switching.
        applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 0);
        cyc("both_bad1", 0, 0, 0, 0, 0, 8'd0);
        cyc("both_bad2", 0, 0, 0, 0, 0, 8'd0);
        cyc("both_faults", 0, 1, 1, 0, 0, 8'd0);
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        cyc("both_dead", 0, 1, 1, 1, 0, 8'd0);
        applyStimulus(1, 1, 8'h00, 8'h00, 1, 0, 0);
        cyc("dd_clr_to_pri", 0, 0, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        cyc("pri_after_clr", 0, 0, 0, 0, 0, 8'd0);

        // Override to channel 1, held past the hold-off, then released.
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 1, 1);
        cyc("force_on", 1, 0, 0, 0, 1, 8'd0);
        for (int i = 0; i < 8; i++) begin
            cyc("force_held", 1, 0, 0, 0, 0, 8'd0);
        end
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        cyc("force_release", 0, 0, 0, 0, 1, 8'd0);
        // Override ignores hold; the release afterwards must respect it.
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 1, 1);
        cyc("force_ignores_hold", 1, 0, 0, 0, 1, 8'd0);
        applyStimulus(1, 1, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc("release_held_off", 1, 0, 0, 0, 0, 8'd0);
        end
        cyc("release_after_hold", 0, 0, 0, 0, 1, 8'd0);

        // Mismatch counter and its saturation.
        applyStimulus(1, 1, 8'h55, 8'hAA, 0, 0, 0);
        cyc("mism_first", 0, 0, 0, 0, 0, 8'd1);
        for (int i = 0; i < 252; i++) begin
            step();
        end
        cyc("mism_254", 0, 0, 0, 0, 0, 8'd254);
        cyc("mism_255", 0, 0, 0, 0, 0, 8'd255);
        for (int i = 0; i < 44; i++) begin
            step();
        end
        cyc("mism_saturated", 0, 0, 0, 0, 0, 8'd255);
        applyStimulus(1, 1, 8'h55, 8'hAA, 1, 0, 0);
        cyc("mism_clr", 0, 0, 0, 0, 0, 8'd0);
        applyStimulus(1, 1, 8'h55, 8'h55, 0, 0, 0);
        cyc("mism_equal_data", 0, 0, 0, 0, 0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/duplex_sel_ctrl.md
DUPLEX_SEL_CTRL -- requirements
Module: duplex_sel_ctrl

Interface
REQ-001 Parameters SHALL be:
  - W, 8: channel data width.
  - THRESH, 3: consecutive invalid cycles before a channel is declared faulty (range 1..15).
  - HOLD, 8: minimum cycles between SL changes (range 1..255).
REQ-002 Ports SHALL be:
  - CK  in  1  sole clock, rising edge.
  - R  in  1  asynchronous, active-high reset.
  - A0  in  W  channel 0 data.
  - A1  in  W  channel 1 data.
  - V0  in  1  channel 0 self-check valid.
  - V1  in  1  channel 1 self-check valid.
  - CLR  in  1  clear faults and counters, one-cycle pulse.
  - FORCE_EN  in  1  manual select override.
  - FORCE_SL  in  1  override select value.
  - SL  out  1  registered mux select; 0 = A0, 1 = A1.
  - FAULT0  out  1  sticky channel 0 fault.
  - FAULT1  out  1  sticky channel 1 fault.
  - DEAD  out  1  both channels faulty.
  - SWITCH  out  1  one-cycle pulse on every SL change.
  - MISM_CNT  out  8  saturating A0/A1 disagreement count.

Function
REQ-003 Every output SHALL be a flop output; no combinational input-to-output path.
REQ-004 Per-channel bad counter behaviour:
  - Increments on each edge where Vx=0.
  - Saturates at THRESH.
  - Clears to 0 on any edge where Vx=1.
REQ-005 FAULTx SHALL set on the edge where the bad counter reaches THRESH, and stay set until CLR or R.
REQ-006 FSM states SHALL be PRI (select 0), SEC (select 1) and DD (both faulty).
REQ-007 FSM transitions:
  - PRI->SEC when FAULT0=1, FAULT1=0, hold expired.
  - SEC->PRI when FAULT1=1, FAULT0=0, hold expired.
  - PRI or SEC -> DD when FAULT0=FAULT1=1.
  - DD->PRI on CLR.
  - Otherwise hold state.
REQ-008 The FSM SHALL evaluate registered FAULTx, so SL changes one edge after FAULTx sets, i.e. THRESH+1 edges after the first sampled Vx=0.
REQ-009 Hold counter SHALL load HOLD on every SL change and decrement to 0; "hold expired" means hold counter = 0.
REQ-010 In DD, SL SHALL hold its last value and DEAD SHALL be 1; DEAD SHALL be 0 in all other states.
REQ-011 FORCE_EN=1:
  - Next-cycle SL = FORCE_SL, ignoring the hold counter.
  - FSM state, fault tracking and counters continue unchanged.
  - On FORCE_EN deassert, SL returns to the FSM value on the next edge, subject to hold.
REQ-012 SWITCH SHALL be 1 for exactly the cycle following any edge on which SL changed, forced or automatic.
REQ-013 MISM_CNT SHALL increment, saturating at 255, on each edge where V0=V1=1 and A0!=A1.
REQ-014 CLR SHALL zero both bad counters, FAULT0, FAULT1 and MISM_CNT.
REQ-015 CLR on the same edge as a counter reaching THRESH: the fault SHALL win and FAULTx SHALL be 1.
REQ-016 CLR in PRI or SEC SHALL NOT change SL.
REQ-017 Simultaneous first faults on both channels SHALL go directly to DD with no intermediate switch.

Reset
REQ-018 R=1 SHALL asynchronously force the following values, independent of CK:
  - state PRI, SL=0.
  - FAULT0=FAULT1=DEAD=SWITCH=0.
  - MISM_CNT=0, bad counters 0, hold counter 0.
REQ-019 R asserted mid-operation, including in DD or during hold, SHALL discard all history.
REQ-020 First evaluation after R deasserts SHALL occur at the next rising CK.

Structure
REQ-021 Package duplex_pkg SHALL hold:
  - the state enum (PRI, SEC, DD).
  - default THRESH/HOLD constants.
  - the MISM_CNT width.
REQ-022 Each channel's bad counter SHALL be one instance of sub-module sat_cnt (parameterised width and limit, with inc/clr inputs).
REQ-023 The block SHALL NOT contain the 2:1 mux itself; SL drives the external mux select.

Verification (W=8, THRESH=3, HOLD=8)
REQ-024 Failover: V0 low 3 cycles from cycle 10 -> FAULT0=1 after edge 12, SL=1 and SWITCH=1 after edge 13.
REQ-025 Hold: after REQ-024, V1 low from cycle 14 -> FAULT1=1 at edge 16, DEAD=1 at edge 17, SL stays 1.
REQ-026 Glitch rejection: V0 low 2 cycles, high 1, low 2 -> FAULT0 stays 0, SL stays 0.
REQ-027 Override: FORCE_EN=1, FORCE_SL=1 at cycle 5 -> SL=1 next edge, SWITCH pulse; release -> SL=0 next edge.
REQ-028 Mismatch: A0=0x55, A1=0xAA, V0=V1=1 for 300 cycles -> MISM_CNT=255; CLR -> 0.
REQ-029 Reset: R pulse mid-DD, asynchronous to CK -> all outputs 0 before next CK edge.
